// File: rtl/dmem_line_ctrl.sv
// Line-granular backing memory behind the L1 data cache: fixed-latency 256-bit
// line reads/writes, one-cycle ack, sticky protocol-error flag.
module dmem_line_ctrl #(
   parameter int unsigned LATENCY = 10,
   parameter int unsigned LINE_AW = 9,
   parameter int unsigned CNT_W   = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         enable_i,
   input  logic         write_i,
   input  logic [31:0]  addr_i,
   input  logic [255:0] data_i,
   output logic [255:0] data_o,
   output logic         ack_o,
   output logic         err_o
);

   localparam int unsigned DEPTH = 2 ** LINE_AW;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACK
   } state_t;

   state_t               state;
   state_t               state_nx;
   logic [CNT_W-1:0]     cnt;
   logic [LINE_AW-1:0]   idx;
   logic [255:0]         line;
   logic                 wr;
   logic [255:0]         mem [DEPTH];
   logic                 unused_addr;

   assign unused_addr = ^{addr_i[31:LINE_AW+5], addr_i[4:0]};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      ack_o    = 1'b0;
      unique case (state)
         S_IDLE: if (enable_i) state_nx = S_WAIT;
         S_WAIT: if (cnt == CNT_W'(1)) state_nx = S_ACK;
         S_ACK: begin
            ack_o    = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt    <= '0;
         idx    <= '0;
         line   <= '0;
         wr     <= 1'b0;
         data_o <= '0;
         err_o  <= 1'b0;
      end else begin
         if (state == S_IDLE && enable_i) begin
            idx  <= addr_i[LINE_AW+4:5];
            line <= data_i;
            wr   <= write_i;
            cnt  <= CNT_INIT;
         end
         if (state == S_WAIT) begin
            cnt <= cnt - 1'b1;
            // Read data is registered on the WAIT->ACK edge so it is valid while ack_o is high.
            if (cnt == CNT_W'(1) && !wr) data_o <= mem[idx];
         end
         if ((state == S_WAIT || state == S_ACK) && !enable_i) err_o <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (state == S_ACK && wr && !rst_i) mem[idx] <= line;
   end

endmodule

// File: tb/tb_dmem_line_ctrl.sv
// Self-checking bench for dmem_line_ctrl: cycle-level reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_dmem_line_ctrl;

   localparam int unsigned LAT = 10;
   localparam int unsigned AW  = 9;

   logic         clk    = 1'b0;
   logic         rst    = 1'b1;
   logic         enable = 1'b0;
   logic         write  = 1'b0;
   logic [31:0]  addr   = '0;
   logic [255:0] wdata  = '0;
   logic [255:0] rdata;
   logic         ack;
   logic         err;

   dmem_line_ctrl #(.LATENCY(LAT), .LINE_AW(AW), .CNT_W(8)) dut (
      .clk_i(clk), .rst_i(rst), .enable_i(enable), .write_i(write),
      .addr_i(addr), .data_i(wdata), .data_o(rdata), .ack_o(ack), .err_o(err)
   );

   always #5 clk = ~clk;

   int passes = 0;
   int total  = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model: an access accepted at edge n acks in the cycle after edge n+LAT-1
   // and frees the port at edge n+LAT; writes land in the line store at that point.
   logic [255:0] mdl_mem [int unsigned];
   int           cyc = 0;
   bit           busy = 0;
   int           start = 0;
   int unsigned  m_idx = 0;
   bit           m_wr = 0;
   logic [255:0] m_data = '0;
   logic         exp_ack = 1'b0;
   logic         exp_err = 1'b0;
   logic [255:0] exp_data = '0;
   bit           exp_known = 1;
   bit           chk_en = 0;
   int           n_acks = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         busy = 0; exp_ack = 1'b0; exp_err = 1'b0; exp_data = '0; exp_known = 1;
      end else begin
         cyc = cyc + 1;
         if (!busy) begin
            exp_ack = 1'b0;
            if (enable) begin
               busy = 1; start = cyc; m_idx = int'(addr[AW+4:5]); m_wr = write; m_data = wdata;
            end
         end else begin
            if (!enable) exp_err = 1'b1;
            if (cyc == start + int'(LAT) - 1) begin
               exp_ack = 1'b1;
               if (!m_wr) begin
                  if (mdl_mem.exists(m_idx)) begin
                     exp_data = mdl_mem[m_idx]; exp_known = 1;
                  end else exp_known = 0;
               end
            end else if (cyc == start + int'(LAT)) begin
               exp_ack = 1'b0;
               if (m_wr) mdl_mem[m_idx] = m_data;
               busy = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ack_o", {255'b0, ack}, {255'b0, exp_ack});
         chk("err_o", {255'b0, err}, {255'b0, exp_err});
         if (exp_known) chk("data_o", rdata, exp_data);
         if (ack === 1'b1) n_acks++;
      end
   end

   // chained: drive immediately (port held from a previous ack) instead of after the next edge.
   task automatic req(input bit wr, input logic [31:0] a, input logic [255:0] d,
                      input bit chained, input bit hold, input int unsigned drop_at,
                      output int e0, output int ackc);
      bit got;
      got = 0;
      ackc = -1;
      if (!chained) begin
         @(posedge clk); #1;
      end
      enable = 1'b1; write = wr; addr = a; wdata = d;
      @(posedge clk); #1;
      e0 = cyc;
      for (int unsigned k = 1; k <= 300; k++) begin
         @(posedge clk); #1;
         if (drop_at != 0 && k == drop_at) enable = 1'b0;
         if (drop_at != 0 && k == drop_at + 1) enable = 1'b1;
         if (ack === 1'b1) begin
            got = 1; ackc = cyc;
            break;
         end
      end
      chk("ack_seen", {255'b0, got}, 256'd1);
      if (got) begin
         chk("latency_edges", 256'(ackc - e0 + 1), 256'd10);
         @(posedge clk); #1;
         chk("ack_pulse", {255'b0, ack}, 256'd0);
         if (!hold) enable = 1'b0;
      end
   endtask

   logic [255:0] pat_a5, pat_1234, pat_wb, pat_20, pat_old, pat_new, pat_wrap;
   int e0, ackc, e0b, ackb, acks0;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      pat_a5   = {32{8'hA5}};
      pat_1234 = {16{16'h1234}};
      pat_wb   = {8{32'hDEAD_BEEF}};
      pat_20   = {8{32'h0BAD_F00D}};
      pat_old  = {4{64'h0123_4567_89AB_CDEF}};
      pat_new  = {4{64'hFEDC_BA98_7654_3210}};
      pat_wrap = {8{32'hCAFE_0042}};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1;
      chk("rst_ack", {255'b0, ack}, 256'd0);
      chk("rst_data", rdata, 256'd0);
      chk("rst_err", {255'b0, err}, 256'd0);

      // Preload line 3, then read it back through 32'h60.
      req(1'b1, 32'h60, pat_a5, 0, 0, 0, e0, ackc);
      req(1'b0, 32'h60, '0, 0, 0, 0, e0, ackc);
      chk("read_60", rdata, pat_a5);

      // Write ack must not disturb data_o; read-after-write sees the new line.
      req(1'b1, 32'h80, pat_1234, 0, 0, 0, e0, ackc);
      chk("data_hold_on_write", rdata, pat_a5);
      req(1'b0, 32'h80, '0, 0, 0, 0, e0, ackc);
      chk("read_80", rdata, pat_1234);

      // Write-back then refill with enable held high.
      req(1'b1, 32'h20, pat_20, 0, 0, 0, e0, ackc);
      acks0 = n_acks;
      req(1'b1, 32'h400, pat_wb, 0, 1, 0, e0, ackc);
      req(1'b0, 32'h20, '0, 1, 0, 0, e0b, ackb);
      chk("b2b_gap", 256'(e0b - ackc), 256'd2);
      chk("b2b_acks", 256'(n_acks - acks0), 256'd2);
      chk("b2b_read", rdata, pat_20);
      chk("b2b_no_err", {255'b0, err}, 256'd0);
      req(1'b0, 32'h400, '0, 0, 0, 0, e0, ackc);
      chk("read_400", rdata, pat_wb);

      // Reset four cycles into a write: nothing committed, outputs cleared at once.
      req(1'b1, 32'hC0, pat_old, 0, 0, 0, e0, ackc);
      req(1'b0, 32'hC0, '0, 0, 0, 0, e0, ackc);
      chk("read_c0_old", rdata, pat_old);
      @(posedge clk); #1;
      enable = 1'b1; write = 1'b1; addr = 32'hC0; wdata = pat_new;
      @(posedge clk); #1;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1; enable = 1'b0;
      #1;
      chk("midrst_ack", {255'b0, ack}, 256'd0);
      chk("midrst_data", rdata, 256'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      acks0 = n_acks;
      repeat (15) @(posedge clk);
      chk("midrst_no_ack", 256'(n_acks - acks0), 256'd0);
      req(1'b0, 32'hC0, '0, 0, 0, 0, e0, ackc);
      chk("read_c0_after_rst", rdata, pat_old);

      // Index bits above LINE_AW alias.
      req(1'b1, 32'h4020, pat_wrap, 0, 0, 0, e0, ackc);
      req(1'b0, 32'h0020, '0, 0, 0, 0, e0, ackc);
      chk("wrap_read", rdata, pat_wrap);

      // Enable drop during WAIT: sticky error, access still completes on time.
      req(1'b0, 32'h80, '0, 0, 0, 3, e0, ackc);
      chk("drop_data", rdata, pat_1234);
      chk("drop_err", {255'b0, err}, 256'd1);
      req(1'b0, 32'h60, '0, 0, 0, 0, e0, ackc);
      chk("err_sticky", {255'b0, err}, 256'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      chk("err_cleared", {255'b0, err}, 256'd0);
      repeat (3) @(posedge clk);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
